// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
//   state_e       : arbiter state (IDLE / OWN)
//   onehot_to_idx : encodes a onehot vector (up to MAX_REQ bits) to its index
//   ID_W          : grant index width for the default NUM=4 configuration
package rr_arb_pkg;

  localparam int unsigned MAX_REQ     = 32;
  localparam int unsigned NUM_DEFAULT = 4;
  localparam int unsigned ID_W        = $clog2(NUM_DEFAULT);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // OR of indices of set bits; exact for onehot inputs, 0 for all-zero.
  function automatic logic [31:0] onehot_to_idx(input logic [MAX_REQ-1:0] vec);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      if (vec[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_fixed_prio.sv
// Combinational fixed-priority arbiter: lowest set request index wins.
//   req_i   : request vector
//   gnt_c_o : onehot0 grant (combinational)
module rr_lock_arbiter_fixed_prio #(
  parameter int unsigned NUM = 4
) (
  input  logic [NUM-1:0] req_i,
  output logic [NUM-1:0] gnt_c_o
);

  // Isolate lowest set bit.
  assign gnt_c_o = req_i & (~req_i + NUM'(1));

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking: an owner keeps the grant while
// requesting, up to MAX_HOLD cycles, then yields if anyone else is waiting.
//   clk, rst_n  : clock, synchronous active-low reset
//   req_i       : level-sensitive request vector
//   gnt_o       : registered onehot0 grant
//   gnt_valid_o : registered, |gnt_o
//   gnt_id_o    : registered index of the owner, 0 when no grant
module rr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM      = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM-1:0]          req_i,
  output logic [NUM-1:0]          gnt_o,
  output logic                    gnt_valid_o,
  output logic [$clog2(NUM)-1:0]  gnt_id_o
);

  localparam int unsigned IDX_W = $clog2(NUM);
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM-1:0]     gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;

  logic [NUM-1:0]     mask;
  logic [NUM-1:0]     masked_req;
  logic [NUM-1:0]     gnt_masked;
  logic [NUM-1:0]     gnt_full;
  logic [NUM-1:0]     winner_oh;
  logic [IDX_W-1:0]   winner_idx;
  logic [NUM-1:0]     ptr_oh;
  logic               other_req;
  logic               owner_req;

  // Requests strictly above the pointer get priority.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      mask[i] = (32'(i) > 32'(ptr_q));
    end
  end

  assign masked_req = req_i & mask;

  rr_lock_arbiter_fixed_prio #(.NUM(NUM)) u_prio_masked (
    .req_i   (masked_req),
    .gnt_c_o (gnt_masked)
  );

  rr_lock_arbiter_fixed_prio #(.NUM(NUM)) u_prio_full (
    .req_i   (req_i),
    .gnt_c_o (gnt_full)
  );

  // Wrap to the full vector only when nobody is above the pointer.
  assign winner_oh  = (|masked_req) ? gnt_masked : gnt_full;
  assign winner_idx = IDX_W'(onehot_to_idx(MAX_REQ'(winner_oh)));

  assign ptr_oh    = NUM'(1) << ptr_q;
  assign owner_req = |(req_i & ptr_oh);
  assign other_req = |(req_i & ~ptr_oh);

  // Next-state logic and registered output values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    gnt_id_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = OWN;
          ptr_d   = winner_idx;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (!owner_req) begin
          cnt_d = '0;
          if (other_req) begin
            ptr_d = winner_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (32'(cnt_q) < MAX_HOLD - 1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Hold limit reached: restart the count; winner is never the
          // owner while someone else is requesting.
          cnt_d = '0;
          if (other_req) ptr_d = winner_idx;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == OWN) begin
      gnt_d       = NUM'(1) << ptr_d;
      gnt_valid_d = 1'b1;
      gnt_id_d    = ptr_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM - 1);
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_id_o    = gnt_id_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (NUM=4, MAX_HOLD=4). Each step drives
// rst_n/req_i, queues the expected grant for the following edge, and checks
// it just after that edge.
module tb_rr_lock_arbiter;
  import rr_arb_pkg::*;

  localparam int unsigned NUM      = 4;
  localparam int unsigned MAX_HOLD = 4;

  logic              clk;
  logic              rst_n;
  logic [NUM-1:0]    req_i;
  logic [NUM-1:0]    gnt_o;
  logic              gnt_valid_o;
  logic [ID_W-1:0]   gnt_id_o;

  logic [NUM-1:0]    exp_q[$];
  int                n_cmp;
  int                n_bad;

  rr_lock_arbiter #(.NUM(NUM), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_id_o    (gnt_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ID_W-1:0] exp_id(input logic [NUM-1:0] oh);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      if (oh[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  // One clock step: drive at negedge, check just after the next posedge.
  task automatic cyc(input logic rst, input logic [NUM-1:0] req,
                     input logic [NUM-1:0] exp, input string tag);
    logic [NUM-1:0] e;
    @(negedge clk);
    rst_n = rst;
    req_i = req;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_bad++;
      $error("FAIL %s scoreboard empty", tag);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    assert (gnt_o === e) else begin
      n_bad++;
      $error("FAIL %s gnt_o observed=%b expected=%b", tag, gnt_o, e);
    end
    n_cmp++;
    assert (gnt_valid_o === (|e)) else begin
      n_bad++;
      $error("FAIL %s gnt_valid_o observed=%b expected=%b", tag, gnt_valid_o, |e);
    end
    n_cmp++;
    assert (gnt_id_o === exp_id(e)) else begin
      n_bad++;
      $error("FAIL %s gnt_id_o observed=%0d expected=%0d", tag, gnt_id_o, exp_id(e));
    end
    n_cmp++;
    assert ($onehot0(gnt_o)) else begin
      n_bad++;
      $error("FAIL %s onehot0 observed=%b expected=onehot0", tag, gnt_o);
    end
  endtask

  initial begin
    logic [NUM-1:0] g;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req_i = '0;

    // Reset, including X requests during reset.
    cyc(1'b0, 4'bxxxx, 4'b0000, "rst_x");
    cyc(1'b0, 4'b1111, 4'b0000, "rst");

    // Saturation: four cycles per requester, rotating without gaps.
    for (int k = 0; k < int'(NUM); k++) begin
      g = 4'b0001 << k;
      for (int h = 0; h < int'(MAX_HOLD); h++) begin
        cyc(1'b1, 4'b1111, g, "sat");
      end
    end
    cyc(1'b1, 4'b1111, 4'b0001, "sat_wrap");

    // Release handoff from a fresh reset.
    cyc(1'b0, 4'b0000, 4'b0000, "rst2");
    cyc(1'b1, 4'b0101, 4'b0001, "rel_first");
    cyc(1'b1, 4'b0101, 4'b0001, "rel_hold");
    cyc(1'b1, 4'b0100, 4'b0100, "rel_handoff");

    // Sole requester keeps the grant across hold boundaries.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 4'b0010, 4'b0010, "sole");
    end

    // Idle with pointer retention, then wrap to index 0.
    cyc(1'b1, 4'b0100, 4'b0100, "own2");
    cyc(1'b1, 4'b0000, 4'b0000, "idle");
    cyc(1'b1, 4'b0101, 4'b0001, "ptr_wrap");
    cyc(1'b1, 4'b0100, 4'b0100, "ptr_next");

    // Reset while owner 3 is mid-hold.
    cyc(1'b1, 4'b1000, 4'b1000, "own3_c0");
    cyc(1'b1, 4'b1000, 4'b1000, "own3_c1");
    cyc(1'b1, 4'b1000, 4'b1000, "own3_c2");
    cyc(1'b0, 4'b1001, 4'b0000, "rst_mid");
    cyc(1'b1, 4'b1001, 4'b0001, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Sequential round-robin arbiter with grant locking; shares one resource among NUM requesters.
- A requester keeps the grant while it holds req_i high, up to MAX_HOLD cycles. After that it is preempted if any other requester is waiting.
- Sits upstream of the shared resource and replaces direct use of the combinational fixed-priority arbiter where fairness and multi-cycle ownership are required.

Parameters:
- NUM, 4, number of requesters (>= 2); index 0 is the tie-break winner.
- MAX_HOLD, 8, maximum consecutive grant cycles before preemption (>= 1); 1 gives per-cycle round-robin.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_i  input  NUM  request vector, level-sensitive.
- gnt_o  output  NUM  registered grant, onehot0.
- gnt_valid_o  output  1  registered; equals |gnt_o.
- gnt_id_o  output  $clog2(NUM)  registered index of the granted requester; 0 when gnt_valid_o is 0.

Behaviour:
- Reset (rst_n == 0 at a clk edge):
  - gnt_o = 0, gnt_valid_o = 0, gnt_id_o = 0.
  - state = IDLE, ptr = NUM-1, hold_cnt = 0.
  - Applies mid-grant too; req_i is ignored on that edge.
- States:
  - IDLE: no grant.
  - OWN: gnt_o[ptr] = 1; ptr is the owner.
- Pick function (combinational, from req_i and ptr):
  - masked = req_i bits with index > ptr.
  - If masked != 0, winner = lowest set index of masked; otherwise winner = lowest set index of req_i.
  - The current owner is therefore chosen only when it is the sole requester.
- IDLE:
  - req_i == 0 -> stay in IDLE.
  - Otherwise -> OWN; ptr = winner, hold_cnt = 0, gnt_o = onehot(winner).
  - Latency: grant is visible one cycle after the request.
- OWN:
  - req_i[ptr] == 0 (release), other requests present -> grant winner next cycle, hold_cnt = 0. No bubble.
  - req_i[ptr] == 0, req_i == 0 -> go to IDLE, gnt_o = 0. ptr is retained for fairness.
  - req_i[ptr] == 1, hold_cnt < MAX_HOLD-1 -> hold the grant, hold_cnt + 1.
  - req_i[ptr] == 1, hold_cnt == MAX_HOLD-1:
    - Any other request present -> preempt to winner (never the owner), hold_cnt = 0.
    - Owner is the sole requester -> keep the grant, hold_cnt = 0 (counter restarts).
- hold_cnt width is $clog2(MAX_HOLD+1). It never exceeds MAX_HOLD-1.
- Because the grant is registered, it persists for one cycle after the owner drops req_i. The resource must qualify grant with req.
- Invariants:
  - gnt_o is onehot0.
  - gnt_o[k] rising implies req_i[k] was 1 on the previous cycle.
  - A continuously requesting input is granted within (NUM-1)*MAX_HOLD+1 cycles.
- req_i may change arbitrarily every cycle. X on req_i during reset is tolerated.

Decomposition:
- Shared package rr_arb_pkg:
  - typedef state_e {IDLE, OWN}.
  - function onehot_to_idx (NUM-generic).
  - constant ID_W = $clog2(NUM).
- Sub-module: reuse the existing fixed-priority arbiter (NUM), instantiated twice.
  - Instance 1 on masked requests, instance 2 on the full req_i.
  - Select by |masked, then encode the result to an index.
- Everything else (state, ptr, hold_cnt, output registers) lives in rr_lock_arbiter.

Test Plan (NUM=4, MAX_HOLD=4):
- Reset / first grant: req_i=4'b1111 with rst_n=0 -> gnt_o=0. Release rst_n at t0 -> gnt_o=4'b0001 at t1, gnt_id_o=0.
- Saturation: req_i=4'b1111 held -> gnt_o = 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001. No gap cycles.
- Release handoff: req_i=4'b0101 at t0 -> gnt_o=0001 at t1. Drop req_i[0] at t2 -> gnt_o=0100 at t3, hold_cnt=0.
- Sole-requester timeout: req_i=4'b0010 for 12 cycles -> gnt_o=0010 continuously, no deassertion at the hold boundary.
- Idle and pointer retention: owner 2 drops and req_i=0 -> gnt_o=0 next cycle. Then req_i=4'b0101 -> gnt_o=0001 (masked empty, wrap), and 0100 is next after 0001 releases.
- Reset mid-grant: owner 3 with hold_cnt=2, rst_n=0 for 1 cycle, req_i=4'b1001 -> gnt_o=0 during reset, then 0001 one cycle after rst_n rises.
